alarm_game_check: RTL and testbench

ALARM_GAME_CHECK -- requirements
Module: alarm_game_check

---
 rtl/alarm_game_check.sv | 166 ++++++++++++++++
 tb/tb_alarm_game_check.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_game_check.sv
// alarm_game_check
//   Alarm service with a "wake-up" mini game. Once armed, the alarm rings
//   when current time equals alarm time. Pressing the middle button starts
//   a game: the switches must be set to the pattern shown on the LEDs for
//   three rounds to turn the alarm off. A press with wrong switches sends
//   the block back to ringing. Dropping the service switch aborts to idle.
//
// Ports
//   clk           system clock (rising edge)
//   resetn        asynchronous active-low reset
//   spdt4         service enable switch (async, synchronized here)
//   current       current time, BCD MM:SS
//   alarm         alarm time, BCD MM:SS
//   push_m        middle push button (async, synchronized + edge detected)
//   mini_game     game switches (async, synchronized here)
//   alarm_state   state code: 0 IDLE, 4 ARMED, 1 RING, 2 GAME, 3 OFF
//   mini_game_led LEDs above the switches
//   ring          alarm indicator, toggles every cycle while ringing
//   round         completed game rounds
//   finish4       high while the alarm is switched off (OFF)
module alarm_game_check (
  input  logic        clk,
  input  logic        resetn,
  input  logic        spdt4,
  input  logic [15:0] current,
  input  logic [15:0] alarm,
  input  logic        push_m,
  input  logic [9:0]  mini_game,
  output logic [2:0]  alarm_state,
  output logic [9:0]  mini_game_led,
  output logic        ring,
  output logic [1:0]  round,
  output logic        finish4
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ARMED = 3'd4;
  localparam logic [2:0] S_RING  = 3'd1;
  localparam logic [2:0] S_GAME  = 3'd2;
  localparam logic [2:0] S_OFF   = 3'd3;

  logic       sp_s1_q, sp_s2_q;
  logic       pm_s1_q, pm_s2_q, pm_prev_q;
  logic [9:0] mg_s1_q, mg_s2_q;
  logic [9:0] lfsr_q, lfsr_d;
  logic [9:0] target_q, target_d;
  logic       match_q, match_d;
  logic [1:0] round_q, round_d;
  logic [2:0] state_q, state_d;
  logic       ring_q, ring_d;
  logic [9:0] led_q, led_d;
  logic       fin_q, fin_d;
  logic       pm_rise;
  logic [9:0] new_tgt;

  assign pm_rise = pm_s2_q & ~pm_prev_q;
  // x^10 + x^7 + 1 Fibonacci form
  assign lfsr_d  = {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};
  // A new target never equals the switches already set, so a fresh round
  // cannot be won without moving a switch.
  assign new_tgt = (lfsr_q == mg_s2_q) ? (lfsr_q ^ 10'h200) : lfsr_q;

  always_comb begin
    state_d  = state_q;
    round_d  = round_q;
    target_d = target_q;
    match_d  = match_q;
    if (!sp_s2_q) begin
      // Service switch off wins over everything else.
      state_d = S_IDLE;
      round_d = 2'd0;
      match_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE:  state_d = S_ARMED;
        S_ARMED: if (current == alarm) state_d = S_RING;
        S_RING: begin
          if (pm_rise) begin
            state_d  = S_GAME;
            round_d  = 2'd0;
            target_d = new_tgt;
            match_d  = 1'b0;
          end
        end
        S_GAME: begin
          if (mg_s2_q == target_q) begin
            // A completed match takes precedence over a simultaneous press.
            if (match_q) begin
              match_d = 1'b0;
              if (round_q == 2'd2) begin
                state_d = S_OFF;
                round_d = 2'd3;
              end else begin
                round_d  = round_q + 2'd1;
                target_d = new_tgt;
              end
            end else begin
              match_d = 1'b1;
            end
          end else begin
            match_d = 1'b0;
            if (pm_rise) begin
              state_d = S_RING;
              round_d = 2'd0;
            end
          end
        end
        S_OFF:   state_d = S_OFF;
        default: state_d = S_IDLE;
      endcase
    end

    // Outputs are derived from the next state so they register together.
    ring_d = (state_d == S_RING) ? ~ring_q : 1'b0;
    case (state_d)
      S_RING:  led_d = {10{ring_d}};
      S_GAME:  led_d = target_d;
      S_OFF:   led_d = 10'h3FF;
      default: led_d = 10'h000;
    endcase
    fin_d = (state_d == S_OFF);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sp_s1_q   <= 1'b0;
      sp_s2_q   <= 1'b0;
      pm_s1_q   <= 1'b0;
      pm_s2_q   <= 1'b0;
      pm_prev_q <= 1'b0;
      mg_s1_q   <= 10'h000;
      mg_s2_q   <= 10'h000;
      lfsr_q    <= 10'h001;
      target_q  <= 10'h000;
      match_q   <= 1'b0;
      round_q   <= 2'd0;
      state_q   <= S_IDLE;
      ring_q    <= 1'b0;
      led_q     <= 10'h000;
      fin_q     <= 1'b0;
    end else begin
      sp_s1_q   <= spdt4;
      sp_s2_q   <= sp_s1_q;
      pm_s1_q   <= push_m;
      pm_s2_q   <= pm_s1_q;
      pm_prev_q <= pm_s2_q;
      mg_s1_q   <= mini_game;
      mg_s2_q   <= mg_s1_q;
      lfsr_q    <= lfsr_d;
      target_q  <= target_d;
      match_q   <= match_d;
      round_q   <= round_d;
      state_q   <= state_d;
      ring_q    <= ring_d;
      led_q     <= led_d;
      fin_q     <= fin_d;
    end
  end

  assign alarm_state   = state_q;
  assign mini_game_led = led_q;
  assign ring          = ring_q;
  assign round         = round_q;
  assign finish4       = fin_q;

endmodule

// File: tb/tb_alarm_game_check.sv
module tb_alarm_game_check;

  logic        clk = 1'b0;
  logic        resetn;
  logic        spdt4;
  logic [15:0] current;
  logic [15:0] alarm;
  logic        push_m;
  logic [9:0]  mini_game;
  logic [2:0]  alarm_state;
  logic [9:0]  mini_game_led;
  logic        ring;
  logic [1:0]  round;
  logic        finish4;

  int total = 0;
  int bad   = 0;

  logic [9:0] m_lfsr, m_lfsr_prev;
  logic [9:0] cur_tgt;

  alarm_game_check dut (
    .clk          (clk),
    .resetn       (resetn),
    .spdt4        (spdt4),
    .current      (current),
    .alarm        (alarm),
    .push_m       (push_m),
    .mini_game    (mini_game),
    .alarm_state  (alarm_state),
    .mini_game_led(mini_game_led),
    .ring         (ring),
    .round        (round),
    .finish4      (finish4)
  );

  always #5 clk = ~clk;

  // Reference LFSR: x^10+x^7+1, seed 001, advancing every cycle.
  // m_lfsr_prev holds the value the LFSR had just before the last edge.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_lfsr      <= 10'h001;
      m_lfsr_prev <= 10'h000;
    end else begin
      m_lfsr_prev <= m_lfsr;
      m_lfsr      <= {m_lfsr[8:0], m_lfsr[9] ^ m_lfsr[6]};
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [9:0] calc_tgt(input logic [9:0] lf, input logic [9:0] mg);
    return (lf == mg) ? (lf ^ 10'h200) : lf;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_state(input logic [2:0] s, input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (alarm_state === s) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Sets the switches to the current target and waits for the round to
  // advance; on success updates cur_tgt to the next expected target.
  task automatic do_round(input logic [1:0] exp_r, output bit ok);
    mini_game = cur_tgt;
    ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (round === exp_r) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok && exp_r != 2'd3) cur_tgt = calc_tgt(m_lfsr_prev, cur_tgt);
  endtask

  // Press (pulse) push_m in RING and wait for GAME; sets cur_tgt.
  task automatic enter_game(output bit ok);
    push_m = 1'b1;
    tick(2);
    push_m = 1'b0;
    wait_state(3'd2, 4, ok);
    cur_tgt = calc_tgt(m_lfsr_prev, mini_game);
  endtask

  task automatic test_reset;
    resetn = 1'b0; spdt4 = 1'b0; current = 16'h0000; alarm = 16'h0000;
    push_m = 1'b0; mini_game = 10'h000;
    tick(3);
    total++; if (alarm_state !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", alarm_state); end
    total++; if (ring !== 1'b0) begin bad++; $display("FAIL reset_ring got=%b exp=0", ring); end
    total++; if (round !== 2'd0) begin bad++; $display("FAIL reset_round got=%0d exp=0", round); end
    total++; if (finish4 !== 1'b0) begin bad++; $display("FAIL reset_finish got=%b exp=0", finish4); end
    total++; if (mini_game_led !== 10'h000) begin bad++; $display("FAIL reset_led got=%h exp=000", mini_game_led); end
    resetn = 1'b1;
  endtask

  task automatic test_arm;
    bit ok;
    alarm = 16'h0105; current = 16'h0103; spdt4 = 1'b1;
    wait_state(3'd4, 5, ok);
    total++; if (!ok) begin bad++; $display("FAIL arm_reach got=%0d exp=4", alarm_state); end
    current = 16'h0104;
    tick(4);
    total++; if (alarm_state !== 3'd4) begin bad++; $display("FAIL arm_hold got=%0d exp=4", alarm_state); end
    current = 16'h0105;
    wait_state(3'd1, 3, ok);
    total++; if (!ok) begin bad++; $display("FAIL ring_reach got=%0d exp=1", alarm_state); end
    total++; if (ring !== 1'b1) begin bad++; $display("FAIL ring_first got=%b exp=1", ring); end
    total++; if (mini_game_led !== 10'h3FF) begin bad++; $display("FAIL ring_led1 got=%h exp=3ff", mini_game_led); end
    tick(1);
    total++; if (ring !== 1'b0) begin bad++; $display("FAIL ring_toggle0 got=%b exp=0", ring); end
    total++; if (mini_game_led !== 10'h000) begin bad++; $display("FAIL ring_led0 got=%h exp=000", mini_game_led); end
    tick(1);
    total++; if (ring !== 1'b1) begin bad++; $display("FAIL ring_toggle1 got=%b exp=1", ring); end
  endtask

  task automatic test_held_button;
    bit ok;
    int leaves;
    push_m = 1'b1;
    wait_state(3'd2, 6, ok);
    cur_tgt = calc_tgt(m_lfsr_prev, mini_game);
    total++; if (!ok) begin bad++; $display("FAIL held_game got=%0d exp=2", alarm_state); end
    total++; if (mini_game_led !== cur_tgt) begin bad++; $display("FAIL held_target got=%h exp=%h", mini_game_led, cur_tgt); end
    total++; if (round !== 2'd0) begin bad++; $display("FAIL held_round got=%0d exp=0", round); end
    leaves = 0;
    for (int i = 0; i < 97; i++) begin
      @(negedge clk);
      if (alarm_state !== 3'd2) leaves++;
    end
    total++; if (leaves != 0) begin bad++; $display("FAIL held_stay got=%0d exp=0 cycles out of GAME", leaves); end
    push_m = 1'b0;
    tick(3);
  endtask

  task automatic test_full_game;
    bit ok;
    for (int r = 1; r <= 3; r++) begin
      do_round(2'(r), ok);
      total++; if (!ok) begin bad++; $display("FAIL game_round%0d got=%0d exp=%0d", r, round, r); end
      if (r < 3) begin
        total++; if (mini_game_led !== cur_tgt) begin bad++; $display("FAIL game_target%0d got=%h exp=%h", r, mini_game_led, cur_tgt); end
      end
    end
    total++; if (alarm_state !== 3'd3) begin bad++; $display("FAIL game_off got=%0d exp=3", alarm_state); end
    total++; if (finish4 !== 1'b1) begin bad++; $display("FAIL game_finish got=%b exp=1", finish4); end
    total++; if (mini_game_led !== 10'h3FF) begin bad++; $display("FAIL game_led got=%h exp=3ff", mini_game_led); end
  endtask

  task automatic test_off_abort;
    bit ok;
    tick(5);
    total++; if (alarm_state !== 3'd3) begin bad++; $display("FAIL off_hold got=%0d exp=3", alarm_state); end
    spdt4 = 1'b0;
    wait_state(3'd0, 3, ok);
    total++; if (!ok) begin bad++; $display("FAIL off_abort got=%0d exp=0", alarm_state); end
    total++; if (round !== 2'd0) begin bad++; $display("FAIL off_round got=%0d exp=0", round); end
    total++; if (finish4 !== 1'b0) begin bad++; $display("FAIL off_finish got=%b exp=0", finish4); end
    total++; if (mini_game_led !== 10'h000) begin bad++; $display("FAIL off_led got=%h exp=000", mini_game_led); end
    tick(5);
    total++; if (alarm_state !== 3'd0) begin bad++; $display("FAIL no_rering got=%0d exp=0", alarm_state); end
    spdt4 = 1'b1;
    wait_state(3'd1, 6, ok);
    total++; if (!ok) begin bad++; $display("FAIL rering got=%0d exp=1", alarm_state); end
  endtask

  task automatic test_penalty;
    bit ok;
    mini_game = 10'h000;
    enter_game(ok);
    total++; if (!ok) begin bad++; $display("FAIL pen_game got=%0d exp=2", alarm_state); end
    total++; if (mini_game_led !== cur_tgt) begin bad++; $display("FAIL pen_target got=%h exp=%h", mini_game_led, cur_tgt); end
    do_round(2'd1, ok);
    do_round(2'd2, ok);
    total++; if (round !== 2'd2) begin bad++; $display("FAIL pen_round2 got=%0d exp=2", round); end
    mini_game = cur_tgt ^ 10'h001;
    tick(3);
    push_m = 1'b1;
    tick(2);
    push_m = 1'b0;
    wait_state(3'd1, 4, ok);
    total++; if (!ok) begin bad++; $display("FAIL pen_ring got=%0d exp=1", alarm_state); end
    total++; if (round !== 2'd0) begin bad++; $display("FAIL pen_round got=%0d exp=0", round); end
    total++; if (ring !== 1'b1) begin bad++; $display("FAIL pen_ringbit got=%b exp=1", ring); end
  endtask

  task automatic test_game_abort;
    bit ok;
    mini_game = 10'h000;
    tick(2);
    enter_game(ok);
    total++; if (!ok) begin bad++; $display("FAIL ab_game got=%0d exp=2", alarm_state); end
    do_round(2'd1, ok);
    spdt4 = 1'b0;
    wait_state(3'd0, 3, ok);
    total++; if (!ok) begin bad++; $display("FAIL ab_idle got=%0d exp=0", alarm_state); end
    total++; if (round !== 2'd0) begin bad++; $display("FAIL ab_round got=%0d exp=0", round); end
    total++; if (ring !== 1'b0) begin bad++; $display("FAIL ab_ring got=%b exp=0", ring); end
    total++; if (mini_game_led !== 10'h000) begin bad++; $display("FAIL ab_led got=%h exp=000", mini_game_led); end
  endtask

  task automatic test_async_reset;
    bit ok;
    mini_game = 10'h000;
    spdt4 = 1'b1;
    wait_state(3'd1, 6, ok);
    enter_game(ok);
    do_round(2'd1, ok);
    total++; if (!(ok && alarm_state === 3'd2)) begin bad++; $display("FAIL ar_pre got=%0d/%0d exp=2/1", alarm_state, round); end
    @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    total++; if (alarm_state !== 3'd0) begin bad++; $display("FAIL ar_state got=%0d exp=0", alarm_state); end
    total++; if (round !== 2'd0) begin bad++; $display("FAIL ar_round got=%0d exp=0", round); end
    total++; if (mini_game_led !== 10'h000) begin bad++; $display("FAIL ar_led got=%h exp=000", mini_game_led); end
    total++; if (ring !== 1'b0 || finish4 !== 1'b0) begin bad++; $display("FAIL ar_flags got=%b%b exp=00", ring, finish4); end
    spdt4 = 1'b0;
    mini_game = 10'h000;
    tick(2);
    resetn = 1'b1;
    tick(4);
    total++; if (alarm_state !== 3'd0) begin bad++; $display("FAIL ar_idle got=%0d exp=0", alarm_state); end
    spdt4 = 1'b1;
    wait_state(3'd1, 6, ok);
    total++; if (!ok) begin bad++; $display("FAIL ar_ring got=%0d exp=1", alarm_state); end
    enter_game(ok);
    total++; if (!ok) begin bad++; $display("FAIL ar_game got=%0d exp=2", alarm_state); end
    total++; if (mini_game_led !== cur_tgt) begin bad++; $display("FAIL ar_lfsr got=%h exp=%h", mini_game_led, cur_tgt); end
  endtask

  initial begin
    test_reset();
    test_arm();
    test_held_button();
    test_full_game();
    test_off_abort();
    test_penalty();
    test_game_abort();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
